// File: rtl/dcr_pkg.sv
// Shared definitions for the device control register bank: register map,
// STATUS/CONTROL bit positions and launch FSM state encoding.
package dcr_pkg;

  localparam int unsigned DCR_THREAD_COUNT = 0;
  localparam int unsigned DCR_BLOCK_DIM    = 1;
  localparam int unsigned DCR_PROGRAM_BASE = 2;
  localparam int unsigned DCR_CONTROL      = 3;
  localparam int unsigned DCR_STATUS       = 4;
  localparam int unsigned DCR_CYCLES       = 5;

  localparam int unsigned CONTROL_LAUNCH = 0;

  localparam int unsigned STATUS_BUSY = 0;
  localparam int unsigned STATUS_DONE = 1;
  localparam int unsigned STATUS_ERR  = 2;

  typedef enum logic [1:0] {
    DCR_IDLE,
    DCR_LAUNCH,
    DCR_RUNNING
  } dcr_state_t;

endpackage

// File: rtl/dcr_launch_fsm.sv
// Kernel launch/completion sequencer: owns state, busy, kernel_start, done sticky
// and, when DCR_CYCLE_COUNTER_EN is defined, the saturating run-cycle counter.
module dcr_launch_fsm
  import dcr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  launch_req,
  input  logic                  tc_zero,
  input  logic                  kernel_done,
  input  logic                  done_clr,
  output logic                  launch_c,
  output logic                  active_c,
  output logic                  kernel_start,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] cycles
);

  dcr_state_t state, state_next;
  logic       kernel_start_c;

  always_ff @(posedge clk) begin
    if (reset) state <= DCR_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      DCR_IDLE:    if (launch_req && !tc_zero) state_next = DCR_LAUNCH;
      DCR_LAUNCH:  state_next = DCR_RUNNING;
      DCR_RUNNING: if (kernel_done) state_next = DCR_IDLE;
      default:     state_next = DCR_IDLE;
    endcase
  end

  always_comb begin
    kernel_start_c = (state == DCR_LAUNCH);
    active_c       = (state != DCR_IDLE);
    launch_c       = (state == DCR_IDLE) && launch_req && !tc_zero;
  end

  // Completion sets done in preference to a same-cycle W1C so the event is not lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      kernel_start <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      kernel_start <= kernel_start_c;
      busy         <= active_c;
      if (state == DCR_RUNNING && kernel_done) done <= 1'b1;
      else if (state == DCR_LAUNCH)            done <= 1'b0;
      else if (done_clr)                       done <= 1'b0;
    end
  end

`ifdef DCR_CYCLE_COUNTER_EN
  always_ff @(posedge clk) begin
    if (reset)                                        cycles <= '0;
    else if (state == DCR_LAUNCH)                     cycles <= '0;
    else if (state == DCR_RUNNING && cycles != '1)    cycles <= cycles + DATA_WIDTH'(1);
  end
`else
  assign cycles = '0;
`endif

endmodule

// File: rtl/dcr_bank.sv
// Device control register bank: host decode, config storage, read mux and launch snapshots.
// Optional cycle counter register enabled by DCR_CYCLE_COUNTER_EN.
module dcr_bank
  import dcr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned PC_WIDTH   = 8,
  localparam int unsigned ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dcr_we,
  input  logic                  dcr_re,
  input  logic [ADDR_WIDTH-1:0] dcr_addr,
  input  logic [DATA_WIDTH-1:0] dcr_wdata,
  output logic [DATA_WIDTH-1:0] dcr_rdata,
  output logic                  dcr_rvalid,
  output logic [DATA_WIDTH-1:0] thread_count,
  output logic [DATA_WIDTH-1:0] block_dim,
  output logic [PC_WIDTH-1:0]   program_base,
  output logic                  kernel_start,
  input  logic                  kernel_done,
  output logic                  busy
);

  logic [DATA_WIDTH-1:0] tc_r, bd_r, pb_r, cycles, rd_c;
  logic cfg_sel_c, lock_c, cfg_ok_c, launch_req_c, tc_zero_c, status_wr_c;
  logic done_clr_c, err_set_c, cyc_wr_c, launch_c, active_c, done, err;

  dcr_launch_fsm #(.DATA_WIDTH(DATA_WIDTH)) u_fsm (
    .clk          (clk),
    .reset        (reset),
    .launch_req   (launch_req_c),
    .tc_zero      (tc_zero_c),
    .kernel_done  (kernel_done),
    .done_clr     (done_clr_c),
    .launch_c     (launch_c),
    .active_c     (active_c),
    .kernel_start (kernel_start),
    .busy         (busy),
    .done         (done),
    .cycles       (cycles)
  );

`ifdef DCR_CYCLE_COUNTER_EN
  assign cyc_wr_c = dcr_we && (dcr_addr == ADDR_WIDTH'(DCR_CYCLES));
`else
  assign cyc_wr_c = 1'b0;
`endif

  // Config slots 0-3 are locked from launch until busy falls after completion.
  always_comb begin
    cfg_sel_c    = dcr_we && (dcr_addr <= ADDR_WIDTH'(DCR_CONTROL));
    lock_c       = busy || active_c;
    cfg_ok_c     = cfg_sel_c && !lock_c;
    launch_req_c = cfg_ok_c && (dcr_addr == ADDR_WIDTH'(DCR_CONTROL)) && dcr_wdata[CONTROL_LAUNCH];
    tc_zero_c    = (tc_r == '0);
    status_wr_c  = dcr_we && (dcr_addr == ADDR_WIDTH'(DCR_STATUS));
    done_clr_c   = status_wr_c && dcr_wdata[STATUS_DONE];
    err_set_c    = (cfg_sel_c && lock_c) || (launch_req_c && tc_zero_c) || cyc_wr_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tc_r <= '0;
      bd_r <= '0;
      pb_r <= '0;
    end else if (cfg_ok_c) begin
      if (dcr_addr == ADDR_WIDTH'(DCR_THREAD_COUNT)) tc_r <= dcr_wdata;
      if (dcr_addr == ADDR_WIDTH'(DCR_BLOCK_DIM))    bd_r <= dcr_wdata;
      if (dcr_addr == ADDR_WIDTH'(DCR_PROGRAM_BASE)) pb_r <= dcr_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      thread_count <= '0;
      block_dim    <= '0;
      program_base <= '0;
    end else if (launch_c) begin
      thread_count <= tc_r;
      block_dim    <= bd_r;
      program_base <= pb_r[PC_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                                    err <= 1'b0;
    else if (err_set_c)                           err <= 1'b1;
    else if (status_wr_c && dcr_wdata[STATUS_ERR]) err <= 1'b0;
  end

  always_comb begin
    rd_c = '0;
    case (dcr_addr)
      ADDR_WIDTH'(DCR_THREAD_COUNT): rd_c = tc_r;
      ADDR_WIDTH'(DCR_BLOCK_DIM):    rd_c = bd_r;
      ADDR_WIDTH'(DCR_PROGRAM_BASE): rd_c = pb_r;
      ADDR_WIDTH'(DCR_STATUS): begin
        rd_c[STATUS_BUSY] = busy;
        rd_c[STATUS_DONE] = done;
        rd_c[STATUS_ERR]  = err;
      end
      ADDR_WIDTH'(DCR_CYCLES):       rd_c = cycles;
      default:                       rd_c = '0;
    endcase
  end

  // Read samples pre-edge state, so a same-cycle write is not visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      dcr_rdata  <= '0;
      dcr_rvalid <= 1'b0;
    end else begin
      dcr_rvalid <= dcr_re;
      if (dcr_re) dcr_rdata <= rd_c;
    end
  end

endmodule

// File: tb/tb_dcr_bank.sv
// Directed self-checking bench for dcr_bank (default parameters); covers the
// DCR_CYCLE_COUNTER_EN behaviour when that macro is defined.
module tb_dcr_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic       dcr_we, dcr_re;
  logic [2:0] dcr_addr;
  logic [7:0] dcr_wdata;
  logic [7:0] dcr_rdata;
  logic       dcr_rvalid;
  logic [7:0] thread_count, block_dim, program_base;
  logic       kernel_start, kernel_done, busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dcr_bank dut (
    .clk          (clk),
    .reset        (reset),
    .dcr_we       (dcr_we),
    .dcr_re       (dcr_re),
    .dcr_addr     (dcr_addr),
    .dcr_wdata    (dcr_wdata),
    .dcr_rdata    (dcr_rdata),
    .dcr_rvalid   (dcr_rvalid),
    .thread_count (thread_count),
    .block_dim    (block_dim),
    .program_base (program_base),
    .kernel_start (kernel_start),
    .kernel_done  (kernel_done),
    .busy         (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [7:0] d);
    dcr_we = 1'b1; dcr_addr = a; dcr_wdata = d;
    tick();
    dcr_we = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] a, output logic [7:0] d, output logic v);
    dcr_re = 1'b1; dcr_addr = a;
    tick();
    dcr_re = 1'b0;
    d = dcr_rdata; v = dcr_rvalid;
  endtask

  task automatic pulse_done();
    kernel_done = 1'b1;
    tick();
    kernel_done = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d; logic v;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    n_cmp++;
    if ({busy, kernel_start, dcr_rvalid} !== 3'b000) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 000", {busy, kernel_start, dcr_rvalid});
    end
    n_cmp++;
    if ({thread_count, block_dim, program_base} !== 24'h0) begin
      n_bad++; $display("FAIL reset_snap: got %h want 000000", {thread_count, block_dim, program_base});
    end
    for (int a = 0; a < 6; a++) begin
      do_read(3'(a), d, v);
      n_cmp++;
      if (v !== 1'b1 || d !== 8'h00) begin
        n_bad++; $display("FAIL reset_read%0d: got v=%b d=%h want v=1 d=00", a, v, d);
      end
    end
    tick();
    n_cmp++;
    if (dcr_rvalid !== 1'b0) begin
      n_bad++; $display("FAIL rvalid_pulse: got %b want 0", dcr_rvalid);
    end
  endtask

  task automatic test_launch();
    logic [7:0] d; logic v;
    do_write(3'd0, 8'd8);
    do_write(3'd1, 8'd4);
    do_write(3'd2, 8'h10);
    do_read(3'd2, d, v);
    n_cmp++;
    if (d !== 8'h10) begin n_bad++; $display("FAIL pb_readback: got %h want 10", d); end
    do_write(3'd3, 8'h01);
    n_cmp++;
    if (kernel_start !== 1'b0) begin n_bad++; $display("FAIL start_early: got %b want 0", kernel_start); end
    tick();
    n_cmp++;
    if ({kernel_start, busy} !== 2'b11) begin
      n_bad++; $display("FAIL start_pulse: got start/busy=%b want 11", {kernel_start, busy});
    end
    n_cmp++;
    if (thread_count !== 8'd8 || block_dim !== 8'd4 || program_base !== 8'h10) begin
      n_bad++; $display("FAIL snapshot: got %h/%h/%h want 08/04/10", thread_count, block_dim, program_base);
    end
    tick();
    n_cmp++;
    if ({kernel_start, busy} !== 2'b01) begin
      n_bad++; $display("FAIL start_single: got start/busy=%b want 01", {kernel_start, busy});
    end
    do_read(3'd3, d, v);
    n_cmp++;
    if (d !== 8'h00) begin n_bad++; $display("FAIL control_read: got %h want 00", d); end
  endtask

  task automatic test_lock();
    logic [7:0] d; logic v;
    do_write(3'd0, 8'd3);
    n_cmp++;
    if (thread_count !== 8'd8) begin n_bad++; $display("FAIL lock_snap: got %0d want 8", thread_count); end
    do_read(3'd0, d, v);
    n_cmp++;
    if (d !== 8'd8) begin n_bad++; $display("FAIL lock_reg0: got %0d want 8", d); end
    do_read(3'd4, d, v);
    n_cmp++;
    if (d !== 8'h05) begin n_bad++; $display("FAIL lock_status: got %h want 05", d); end
    pulse_done();
    do_read(3'd4, d, v);
    n_cmp++;
    if (d !== 8'h07) begin n_bad++; $display("FAIL done_status: got %h want 07", d); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_fall: got %b want 0", busy); end
    do_write(3'd4, 8'h06);
    do_read(3'd4, d, v);
    n_cmp++;
    if (d !== 8'h00) begin n_bad++; $display("FAIL w1c: got %h want 00", d); end
    do_write(3'd0, 8'd9);
    do_read(3'd0, d, v);
    n_cmp++;
    if (d !== 8'd9 || thread_count !== 8'd8) begin
      n_bad++; $display("FAIL post_done_write: got reg=%0d out=%0d want 9/8", d, thread_count);
    end
  endtask

  task automatic test_zero_launch();
    logic [7:0] d; logic v; logic seen;
    do_write(3'd0, 8'd0);
    do_write(3'd3, 8'h01);
    seen = kernel_start | busy;
    for (int i = 0; i < 3; i++) begin tick(); seen = seen | kernel_start | busy; end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL zero_launch: got start/busy seen=%b want 0", seen); end
    do_read(3'd4, d, v);
    n_cmp++;
    if (d !== 8'h04) begin n_bad++; $display("FAIL zero_err: got %h want 04", d); end
    do_write(3'd4, 8'h04);
  endtask

  task automatic test_rw_same_cycle();
    logic [7:0] d; logic v;
    dcr_we = 1'b1; dcr_re = 1'b1; dcr_addr = 3'd1; dcr_wdata = 8'h55;
    tick();
    dcr_we = 1'b0; dcr_re = 1'b0;
    n_cmp++;
    if (dcr_rdata !== 8'd4) begin n_bad++; $display("FAIL rw_old: got %h want 04", dcr_rdata); end
    do_read(3'd1, d, v);
    n_cmp++;
    if (d !== 8'h55) begin n_bad++; $display("FAIL rw_new: got %h want 55", d); end
  endtask

  task automatic test_unmapped();
    logic [7:0] d; logic v;
    do_write(3'd6, 8'hFF);
    do_write(3'd7, 8'hAA);
    do_read(3'd6, d, v);
    n_cmp++;
    if (d !== 8'h00) begin n_bad++; $display("FAIL slot6: got %h want 00", d); end
    do_read(3'd4, d, v);
    n_cmp++;
    if (d !== 8'h00) begin n_bad++; $display("FAIL unmapped_err: got %h want 00", d); end
    do_write(3'd5, 8'h12);
    do_read(3'd4, d, v);
    n_cmp++;
`ifdef DCR_CYCLE_COUNTER_EN
    if (d !== 8'h04) begin n_bad++; $display("FAIL cycles_wr_err: got %h want 04", d); end
    do_write(3'd4, 8'h04);
`else
    if (d !== 8'h00) begin n_bad++; $display("FAIL cycles_wr_noerr: got %h want 00", d); end
`endif
  endtask

  task automatic test_cycles();
    logic [7:0] d; logic v;
    do_write(3'd0, 8'd2);
    do_write(3'd3, 8'h01);
    tick();
    repeat (9) tick();
    pulse_done();
    repeat (2) tick();
    do_read(3'd5, d, v);
    n_cmp++;
`ifdef DCR_CYCLE_COUNTER_EN
    if (d !== 8'd10) begin n_bad++; $display("FAIL cycles10: got %0d want 10", d); end
    do_write(3'd3, 8'h01);
    tick();
    repeat (299) tick();
    pulse_done();
    repeat (2) tick();
    do_read(3'd5, d, v);
    n_cmp++;
    if (d !== 8'd255) begin n_bad++; $display("FAIL cycles_sat: got %0d want 255", d); end
`else
    if (d !== 8'd0) begin n_bad++; $display("FAIL cycles_off: got %0d want 0", d); end
`endif
    do_write(3'd4, 8'h06);
  endtask

  task automatic test_reset_midrun();
    logic [7:0] d; logic v;
    do_write(3'd0, 8'd5);
    do_write(3'd3, 8'h01);
    repeat (3) tick();
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL midrun_busy: got %b want 1", busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if ({busy, thread_count} !== 9'h0) begin
      n_bad++; $display("FAIL abort: got busy=%b tc=%0d want 0/0", busy, thread_count);
    end
    for (int a = 0; a < 5; a++) begin
      do_read(3'(a), d, v);
      n_cmp++;
      if (d !== 8'h00) begin n_bad++; $display("FAIL abort_reg%0d: got %h want 00", a, d); end
    end
    pulse_done();
    tick();
    do_read(3'd4, d, v);
    n_cmp++;
    if (d !== 8'h00) begin n_bad++; $display("FAIL abort_done: got %h want 00", d); end
  endtask

  initial begin
    reset = 1'b1; dcr_we = 1'b0; dcr_re = 1'b0; dcr_addr = '0; dcr_wdata = '0; kernel_done = 1'b0;
    test_reset();
    test_launch();
    test_lock();
    test_zero_launch();
    test_rw_same_cycle();
    test_unmapped();
    test_cycles();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
